// File: rtl/mux_sel_pipe.sv
// Parameterised N-way word select feeding a two-entry valid/ready pipe
// (output register plus skid register) with a transfer counter.
module mux_sel_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             xfer_cnt
);

  // Returns {err, word}; any select without a matching input yields err with a zero word.
  function automatic logic [WIDTH:0] pick_word(
    input logic [NUM_IN*WIDTH-1:0] data,
    input logic [SEL_W-1:0]        s
  );
    logic [WIDTH:0] res;
    res = {1'b1, {WIDTH{1'b0}}};
    for (int k = 0; k < NUM_IN; k++) begin
      if (s == SEL_W'(k)) begin
        res = {1'b0, data[k*WIDTH +: WIDTH]};
      end
    end
    return res;
  endfunction

  logic [WIDTH-1:0] skid_data_r;
  logic             skid_err_r;
  logic             skid_valid_r;
  logic [WIDTH:0]   pick_s;
  logic             accept_s;
  logic             load_s;
  logic             xfer_s;

  // Ready depends only on skid occupancy, so no path from out_ready reaches in_ready.
  assign in_ready = ~skid_valid_r;
  assign pick_s   = pick_word(in_data, sel);
  assign accept_s = in_valid & ~skid_valid_r;
  assign load_s   = ~out_valid | out_ready;
  assign xfer_s   = out_valid & out_ready;

  // Output and skid registers plus the transfer counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data     <= {WIDTH{1'b0}};
      out_err      <= 1'b0;
      out_valid    <= 1'b0;
      skid_data_r  <= {WIDTH{1'b0}};
      skid_err_r   <= 1'b0;
      skid_valid_r <= 1'b0;
      xfer_cnt     <= 16'd0;
    end else begin
      if (xfer_s) begin
        xfer_cnt <= xfer_cnt + 16'd1;
      end
      if (load_s) begin
        // Skid holds the older word, so it always drains first; no accept can coincide.
        if (skid_valid_r) begin
          out_data     <= skid_data_r;
          out_err      <= skid_err_r;
          out_valid    <= 1'b1;
          skid_valid_r <= 1'b0;
        end else if (accept_s) begin
          out_data  <= pick_s[WIDTH-1:0];
          out_err   <= pick_s[WIDTH];
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept_s) begin
        skid_data_r  <= pick_s[WIDTH-1:0];
        skid_err_r   <= pick_s[WIDTH];
        skid_valid_r <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mux_sel_pipe.md
MUX_SEL_PIPE -- requirements
Module: mux_sel_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 Parameter WIDTH SHALL default to 32 and set the data width of each input and of the output (legal range 1..64).
REQ-003 Parameter NUM_IN SHALL default to 3 and set the number of data inputs (legal range 2..8).
REQ-004 Parameter SEL_W SHALL default to 2 and set the select width; SEL_W SHALL satisfy 2^SEL_W >= NUM_IN.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-008 sel  input  SEL_W  binary select, sampled with in_data.
REQ-009 in_valid  input  1  upstream offers in_data and sel.
REQ-010 in_ready  output  1  block can accept this cycle.
REQ-011 out_data  output  WIDTH  selected word.
REQ-012 out_err  output  1  the word in out_data came from an illegal select.
REQ-013 out_valid  output  1  out_data and out_err are valid.
REQ-014 out_ready  input  1  downstream accepts this cycle.
REQ-015 xfer_cnt  output  16  count of completed output transfers.

Function
REQ-016 Accept SHALL occur when in_valid and in_ready are both 1 at a rising edge; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-017 Selection: sel < NUM_IN SHALL select input sel with err 0; sel >= NUM_IN SHALL produce an all-zero word with err 1, and every sel value SHALL give a defined result with no latch.
REQ-018 Storage: an output register (out_data, out_err, out_valid) and one skid register (data, err, skid_valid).
REQ-019 in_ready SHALL equal NOT skid_valid, driven from a register with no combinational path from out_ready.
REQ-020 Output register load: when out_valid is 0 or out_ready is 1, the output register SHALL load from the skid register if skid_valid is 1, otherwise from the accepted input; if neither exists, out_valid SHALL go to 0.
REQ-021 Skid load: on an accept while out_valid is 1 and out_ready is 0, the word SHALL go into the skid register and skid_valid SHALL become 1.
REQ-022 Skid drain: when the output register loads from the skid register, skid_valid SHALL clear unless the same edge also loads a new word into the skid register.
REQ-023 Latency: an accepted word SHALL appear with out_valid 1 on the edge after acceptance when the pipe is empty.
REQ-024 Throughput: with out_ready held at 1, the block SHALL accept one word per cycle continuously.
REQ-025 Ordering: words SHALL leave in acceptance order, with none lost or duplicated.
REQ-026 Stall: while out_valid is 1 and out_ready is 0, out_data and out_err SHALL stay stable.
REQ-027 Full: with both registers occupied, in_ready SHALL be 0 and no accept SHALL occur.
REQ-028 Simultaneous accept and output transfer while skid is empty: the new word SHALL go directly to the output register.
REQ-029 xfer_cnt SHALL increment by 1 on each output transfer and wrap from 16'hFFFF to 0.
REQ-030 Inputs that change while in_valid is 0 SHALL have no effect.

Reset
REQ-031 On a rising edge with reset 1: out_valid, skid_valid and out_err SHALL be 0, out_data SHALL be 0, skid data SHALL be 0, and xfer_cnt SHALL be 0.
REQ-032 in_ready SHALL be 1 from the first edge after reset.
REQ-033 Reset asserted mid-stream SHALL discard all held words, and no transfer SHALL be counted on that edge.

Verification
REQ-034 Basic select (NUM_IN=3, WIDTH=32): inputs 0x11/0x22/0x33, sel=1, in_valid 1 for one cycle, out_ready=1 -> next cycle out_valid=1, out_data=0x22, out_err=0; xfer_cnt becomes 1.
REQ-035 Illegal select: sel=3 with NUM_IN=3 -> out_data=0, out_err=1, out_valid=1 one cycle later.
REQ-036 Backpressure: stream sel=0,1,2 on back-to-back cycles with out_ready=0 -> in_ready drops to 0 after 2 accepts; release out_ready -> outputs 0x11, then 0x22; the third word is then accepted and output as 0x33 in order.
REQ-037 Streaming: 100 words with out_ready=1 and in_valid=1 -> in_ready stays 1, one output per cycle, xfer_cnt=100.
REQ-038 Wrap: preload traffic to 65535 transfers, then 1 more -> xfer_cnt=0.
REQ-039 Mid-operation reset: both registers full, reset pulsed for one cycle -> out_valid=0, in_ready=1, xfer_cnt=0 on the next cycle, and no stale word appears afterwards.
